mod_exp_ctrl: RTL and testbench

- Left-to-right square-and-multiply controller for modular exponentiation, result = X^E mod M.
- Acts as the initiator that sequences the Montgomery-product engine (mon_prod) through its start/stop handshake.
- Performs the Montgomery domain entry and exit and the final conditional subtraction.
- Sits between the RSA top-level command logic and the mon_prod instance.

---
 rtl/mod_exp_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller computing X^E mod M.
// Drives an external Montgomery-product engine through a start/stop
// handshake: Montgomery entry of X and 1, one squaring per exponent bit
// (MSB first, leading zeros included), one multiply per set bit, exit
// by a product with 1, then a final conditional subtraction of M.
// Intermediate values live at BITLEN+1 bits (engine output is < 2M) and
// are handed back to the engine truncated to BITLEN, so the modulus must
// satisfy 2M < 2^BITLEN.
module mod_exp_ctrl #(
  parameter int BITLEN  = 64,
  parameter int EXP_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [BITLEN-1:0] X,
  input  logic [EXP_LEN-1:0] E,
  input  logic [BITLEN-1:0] M,
  input  logic [BITLEN-1:0] R2,
  output logic              busy,
  output logic              done,
  output logic [BITLEN-1:0] result,
  output logic              mp_start,
  output logic [BITLEN-1:0] mp_A,
  output logic [BITLEN-1:0] mp_B,
  output logic [BITLEN-1:0] mp_M,
  input  logic              mp_stop,
  input  logic [BITLEN:0]   mp_P
);

  localparam int IW = (EXP_LEN > 1) ? $clog2(EXP_LEN) : 1;
  localparam logic [IW-1:0]     TOP_IDX = IW'(EXP_LEN - 1);
  localparam logic [BITLEN-1:0] ONE     = BITLEN'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRE_X,
    PRE_ONE,
    SQR,
    MUL,
    POST,
    REDUCE,
    DONE
  } state_e;

  // Handshake sub-phase shared by every engine operation state.
  typedef enum logic [1:0] {
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } phase_e;

  state_e state_q;
  phase_e phase_q;

  // Operands latched when a request is accepted.
  logic [BITLEN-1:0]  x_q;
  logic [EXP_LEN-1:0] e_q;
  logic [BITLEN-1:0]  m_q;
  logic [BITLEN-1:0]  r2_q;

  // Running accumulator and Montgomery-form base, both kept unreduced (< 2M).
  logic [BITLEN:0]    a_q;
  logic [BITLEN:0]    xb_q;

  // Exponent bit currently being processed.
  logic [IW-1:0]      idx_q;

  // Registered outputs.
  logic               busy_q;
  logic               done_q;
  logic [BITLEN-1:0]  result_q;
  logic               mp_start_q;
  logic [BITLEN-1:0]  mp_a_q;
  logic [BITLEN-1:0]  mp_b_q;

  // Combinational helpers evaluated from the current state.
  logic [BITLEN-1:0]  op_a_d;
  logic [BITLEN-1:0]  op_b_d;
  logic               bit_set_d;
  logic               last_bit_d;
  logic               is_op_state_d;
  logic               ge_m_d;
  logic [BITLEN-1:0]  reduce_d;

  // Operand pair presented to the engine for the operation of each state.
  always_comb begin
    op_a_d = '0;
    op_b_d = '0;
    case (state_q)
      PRE_X: begin
        op_a_d = x_q;
        op_b_d = r2_q;
      end
      PRE_ONE: begin
        op_a_d = ONE;
        op_b_d = r2_q;
      end
      SQR: begin
        op_a_d = a_q[BITLEN-1:0];
        op_b_d = a_q[BITLEN-1:0];
      end
      MUL: begin
        op_a_d = a_q[BITLEN-1:0];
        op_b_d = xb_q[BITLEN-1:0];
      end
      POST: begin
        op_a_d = a_q[BITLEN-1:0];
        op_b_d = ONE;
      end
      default: begin
        op_a_d = '0;
        op_b_d = '0;
      end
    endcase
  end

  // Exponent bit inspection and operation-state decode.
  always_comb begin
    bit_set_d     = e_q[idx_q];
    last_bit_d    = (idx_q == '0);
    is_op_state_d = (state_q == PRE_X) || (state_q == PRE_ONE) ||
                    (state_q == SQR)   || (state_q == MUL)     ||
                    (state_q == POST);
  end

  // Final conditional subtraction; the difference always fits in BITLEN
  // bits because a < 2M means a - M < M.
  always_comb begin
    ge_m_d   = (a_q >= {1'b0, m_q});
    reduce_d = ge_m_d ? (a_q[BITLEN-1:0] - m_q) : a_q[BITLEN-1:0];
  end

  // Main sequencer: top-level state, handshake phase, datapath registers
  // and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= ISSUE;
      x_q        <= '0;
      e_q        <= '0;
      m_q        <= '0;
      r2_q       <= '0;
      a_q        <= '0;
      xb_q       <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      mp_start_q <= 1'b0;
      mp_a_q     <= '0;
      mp_b_q     <= '0;
    end else begin
      done_q     <= 1'b0;
      mp_start_q <= 1'b0;

      if (state_q == IDLE) begin
        if (go) begin
          x_q     <= X;
          e_q     <= E;
          m_q     <= M;
          r2_q    <= R2;
          busy_q  <= 1'b1;
          phase_q <= ISSUE;
          state_q <= PRE_X;
        end
      end else if (is_op_state_d) begin
        case (phase_q)
          // Only start once the engine reports idle; a run that follows
          // an abandoned one may find the engine still busy.
          ISSUE: begin
            if (mp_stop) begin
              mp_a_q     <= op_a_d;
              mp_b_q     <= op_b_d;
              mp_start_q <= 1'b1;
              phase_q    <= WAIT_BUSY;
            end
          end
          WAIT_BUSY: begin
            if (!mp_stop) begin
              phase_q <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (mp_stop) begin
              phase_q <= ISSUE;
              case (state_q)
                PRE_X: begin
                  xb_q    <= mp_P;
                  state_q <= PRE_ONE;
                end
                PRE_ONE: begin
                  a_q     <= mp_P;
                  idx_q   <= TOP_IDX;
                  state_q <= SQR;
                end
                SQR: begin
                  a_q <= mp_P;
                  if (bit_set_d) begin
                    state_q <= MUL;
                  end else if (last_bit_d) begin
                    state_q <= POST;
                  end else begin
                    idx_q <= idx_q - 1'b1;
                  end
                end
                MUL: begin
                  a_q <= mp_P;
                  if (last_bit_d) begin
                    state_q <= POST;
                  end else begin
                    idx_q   <= idx_q - 1'b1;
                    state_q <= SQR;
                  end
                end
                POST: begin
                  a_q     <= mp_P;
                  state_q <= REDUCE;
                end
                default: state_q <= IDLE;
              endcase
            end
          end
          default: phase_q <= ISSUE;
        endcase
      end else if (state_q == REDUCE) begin
        result_q <= reduce_d;
        done_q   <= 1'b1;
        busy_q   <= 1'b0;
        state_q  <= DONE;
      end else begin
        // DONE: the done pulse is visible for this single cycle.
        state_q <= IDLE;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign mp_start = mp_start_q;
  assign mp_A     = mp_a_q;
  assign mp_B     = mp_b_q;
  assign mp_M     = m_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural Montgomery engine with programmable
// latency, stimulus that queues hand-computed expectations, and a monitor
// that checks each done pulse and handshake rules against the queue.
module tb_mod_exp_ctrl;

  localparam int BITLEN  = 64;
  localparam int EXP_LEN = 64;
  localparam logic [63:0] MOD  = 64'd11;
  localparam logic [63:0] R2V  = 64'd3;   // (2^64)^2 mod 11
  localparam logic [63:0] RINV = 64'd9;   // 2^64 = 5 mod 11, 5*9 = 45 = 1 mod 11

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              go = 1'b0;
  logic [63:0]       X = '0;
  logic [63:0]       E = '0;
  logic [63:0]       M = '0;
  logic [63:0]       R2 = '0;
  logic              busy;
  logic              done;
  logic [63:0]       result;
  logic              mp_start;
  logic [63:0]       mp_A;
  logic [63:0]       mp_B;
  logic [63:0]       mp_M;
  logic              mp_stop = 1'b1;
  logic [64:0]       mp_P = '0;

  mod_exp_ctrl #(.BITLEN(BITLEN), .EXP_LEN(EXP_LEN)) dut (
    .clk(clk), .rst(rst), .go(go), .X(X), .E(E), .M(M), .R2(R2),
    .busy(busy), .done(done), .result(result),
    .mp_start(mp_start), .mp_A(mp_A), .mp_B(mp_B), .mp_M(mp_M),
    .mp_stop(mp_stop), .mp_P(mp_P)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          starts;
  } exp_t;

  exp_t exp_q[$];

  // Stimulus-owned control.
  int          go_seq = 0;
  int          exp_runs = 0;
  bit          rand_delay = 1'b0;
  bit          ab_chk_en = 1'b1;
  bit          rst_chk = 1'b0;
  bit          idle_chk = 1'b0;
  bit          end_req = 1'b0;
  bit          ovr_en = 1'b0;
  int          ovr_at = 0;
  logic [64:0] ovr_val = '0;

  // Monitor-owned state.
  int errors = 0;
  int checks = 0;
  int mon_seq = 0;
  int start_cnt = 0;
  int busy_low = 0;
  int run_cyc = 0;
  int done_cnt = 0;
  int cyc = 0;
  bit in_run = 1'b0;

  // Engine-model state.
  bit          eng_busy = 1'b0;
  bit          cap_pending = 1'b0;
  int          eng_cnt = 0;
  logic [31:0] eng_ops = '0;
  logic [63:0] eng_a = '0;
  logic [63:0] eng_b = '0;
  logic [64:0] eng_res = '0;

  function automatic logic [64:0] mont(input logic [63:0] a, input logic [63:0] b,
                                       input logic odd);
    logic [63:0] r;
    r = ((a % MOD) * (b % MOD)) % MOD;
    r = (r * RINV) % MOD;
    mont = odd ? ({1'b0, r} + {1'b0, MOD}) : {1'b0, r};
  endfunction

  // Behavioural engine: accepts a start while idle, stays busy for the
  // chosen number of cycles, then presents the product with stop high.
  always @(posedge clk) begin
    cap_pending <= 1'b0;
    if (!eng_busy) begin
      if (mp_start && mp_stop) begin
        eng_busy <= 1'b1;
        mp_stop  <= 1'b0;
        eng_a    <= mp_A;
        eng_b    <= mp_B;
        eng_ops  <= eng_ops + 1;
        eng_cnt  <= rand_delay ? int'($urandom_range(20, 1)) : 3;
        eng_res  <= (ovr_en && start_cnt == ovr_at) ? ovr_val
                                                    : mont(mp_A, mp_B, eng_ops[0]);
      end
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end else begin
      eng_busy    <= 1'b0;
      mp_stop     <= 1'b1;
      mp_P        <= eng_res;
      cap_pending <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (go_seq != mon_seq) begin
      mon_seq   = go_seq;
      start_cnt = 0;
      busy_low  = 0;
      run_cyc   = 0;
      in_run    = 1'b1;
    end
    if (mp_start) begin
      start_cnt++;
      check("start_while_engine_busy", mp_stop, 1);
    end
    if (in_run) begin
      run_cyc++;
      if (!busy && !done) busy_low++;
      if (run_cyc > 4000) begin
        checks++;
        errors++;
        $display("FAIL run_timeout: got no done after %0d cycles expected done", run_cyc);
        in_run = 1'b0;
      end
    end
    if (ab_chk_en && (eng_busy || cap_pending)) begin
      check("mp_A_stable", mp_A, eng_a);
      check("mp_B_stable", mp_B, eng_b);
    end
    if (rst_chk) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_mp_start", mp_start, 0);
      check("rst_mp_A", mp_A, 0);
      check("rst_mp_B", mp_B, 0);
      check("rst_mp_M", mp_M, 0);
    end
    if (idle_chk) check("idle_busy", busy, 0);
    if (done) begin
      exp_t t;
      done_cnt++;
      in_run = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_done: got done with result %0d expected no done", result);
      end else begin
        t = exp_q.pop_front();
        $display("done #%0d: result=%0d starts=%0d cycles=%0d", done_cnt, result,
                 start_cnt, run_cyc);
        check("result", result, t.res);
        check("start_count", start_cnt, t.starts);
        check("busy_gap", busy_low, 0);
        check("mp_M", mp_M, MOD);
      end
    end
    if (end_req || cyc > 90000) begin
      if (cyc > 90000) begin
        checks++;
        errors++;
        $display("FAIL global_timeout: got %0d cycles expected fewer", cyc);
      end
      check("queue_empty", exp_q.size(), 0);
      check("done_count", done_cnt, exp_runs);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic do_go(input logic [63:0] x, input logic [63:0] e, input bit push,
                       input logic [63:0] res, input int starts);
    exp_t t;
    @(posedge clk); #1;
    X = x; E = e; M = MOD; R2 = R2V; go = 1'b1;
    if (push) begin
      t.res = res;
      t.starts = starts;
      exp_q.push_back(t);
      exp_runs++;
    end
    @(posedge clk); #1;
    go = 1'b0;
    go_seq++;
    // Scramble inputs: the run must use the values latched at go.
    X = {32'd0, $urandom}; E = {$urandom, $urandom}; M = {$urandom, $urandom} | 64'd1;
    R2 = {32'd0, $urandom};
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_chk = 1'b1;
    @(posedge clk); #1;
    rst_chk = 1'b0;
    rst = 1'b0;

    // 4^13 mod 11 = 9, 3 + 64 + 3 engine ops.
    do_go(64'd4, 64'd13, 1'b1, 64'd9, 70);
    wait_done(1);
    // 7^1 = 7, E = 0 gives 1.
    do_go(64'd7, 64'd1, 1'b1, 64'd7, 68);
    wait_done(2);
    do_go(64'd5, 64'd0, 1'b1, 64'd1, 67);
    wait_done(3);

    // Random engine latency per operation.
    rand_delay = 1'b1;
    do_go(64'd4, 64'd13, 1'b1, 64'd9, 70);
    wait_done(4);
    rand_delay = 1'b0;

    // A second go mid-run must be ignored.
    do_go(64'd4, 64'd13, 1'b1, 64'd9, 70);
    repeat (100) @(posedge clk);
    #1 X = 64'd2; M = MOD; R2 = R2V; go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    wait_done(5);
    repeat (100) @(posedge clk);

    // Reset during the first squaring, then a fresh run: 3^5 = 243 = 1 mod 11.
    do_go(64'd4, 64'd13, 1'b1, 64'd0, 0);
    void'(exp_q.pop_back());
    exp_runs--;
    for (int n = 0; n < 2000 && start_cnt < 3; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 ab_chk_en = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst_chk = 1'b1;
    @(posedge clk); #1 rst_chk = 1'b0; rst = 1'b0;
    for (int n = 0; n < 200 && (eng_busy || cap_pending); n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 ab_chk_en = 1'b1;
    do_go(64'd3, 64'd5, 1'b1, 64'd1, 69);
    wait_done(6);

    // go in the same cycle as rst is ignored.
    @(posedge clk); #1;
    rst = 1'b1; go = 1'b1; X = 64'd4; E = 64'd13; M = MOD; R2 = R2V;
    @(posedge clk); #1;
    rst = 1'b0; go = 1'b0; idle_chk = 1'b1;
    repeat (40) @(posedge clk);
    #1 idle_chk = 1'b0;

    // Reduction boundary: final Montgomery value M+2 and M-1.
    ovr_en = 1'b1;
    ovr_at = 70;
    ovr_val = 65'd13;
    do_go(64'd4, 64'd13, 1'b1, 64'd2, 70);
    wait_done(7);
    ovr_val = 65'd10;
    do_go(64'd4, 64'd13, 1'b1, 64'd10, 70);
    wait_done(8);
    ovr_en = 1'b0;

    repeat (20) @(posedge clk);
    end_req = 1'b1;
  end

endmodule
